// File: rtl/frame_fill_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : frame_fill_ctrl
//  Purpose  : Frame-level sequencer for the DVP video path. Crops lines past
//             V_DISP, pads short frames with fill lines, and flags overruns.
//             Define FRAME_FILL_DEBUG_COLOR_EN to paint fill lines magenta.
//  Revision : 1.0  initial release
// ============================================================================
module frame_fill_ctrl #(
    parameter logic [11:0] H_DISP = 12'd1280,
    parameter logic [11:0] V_DISP = 12'd720,
    parameter logic [11:0] H_GAP  = 12'd16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        vsync_i,
    input  logic [23:0] data_i,
    input  logic        dataValid_i,
    output logic [23:0] data_o,
    output logic        dataValid_o,
    output logic        eof_o,
    output logic        overrun_o,
    output logic        ovr_sticky_o,
    output logic        busy_o,
    output logic [11:0] line_cnt_o
);

`ifdef FRAME_FILL_DEBUG_COLOR_EN
    localparam logic [23:0] C_FILL = 24'hFF00FF;
`else
    localparam logic [23:0] C_FILL = 24'h000000;
`endif

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_PASS      = 2'd1,
        ST_FILL_LINE = 2'd2,
        ST_FILL_GAP  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic        vs_q, dv_q;
    logic [11:0] px_cnt_q, px_cnt_d;
    logic [11:0] line_cnt_q, line_cnt_d;
    logic [11:0] fill_rem_q, fill_rem_d;
    logic [11:0] pxf_cnt_q, pxf_cnt_d;
    logic [11:0] gap_cnt_q, gap_cnt_d;
    logic [23:0] data_q, data_d;
    logic        dvo_q, dvo_d;
    logic        eof_q, eof_d;
    logic        ovr_q, ovr_d;
    logic        sticky_q, sticky_d;
    logic        busy_q, busy_d;

    logic        w_vs_rise;
    logic        w_line_end;
    logic        w_px_ok;
    logic        w_filling;
    logic        w_abort;
    logic [12:0] w_eff_sum;
    logic [11:0] w_eff;

    assign w_vs_rise  = vsync_i & ~vs_q;
    assign w_line_end = dv_q & ~dataValid_i;
    assign w_px_ok    = (px_cnt_q < H_DISP);
    assign w_filling  = (state_q == ST_FILL_LINE) || (state_q == ST_FILL_GAP);
    assign w_abort    = w_filling && (dataValid_i || w_vs_rise);

    // A line still active (or ending) at vsync counts as complete, exactly once.
    assign w_eff_sum  = {1'b0, line_cnt_q} + {12'd0, dv_q};
    assign w_eff      = (w_eff_sum >= {1'b0, V_DISP}) ? V_DISP : w_eff_sum[11:0];

    always_comb begin
        px_cnt_d = px_cnt_q;
        if (dataValid_i) begin
            if (px_cnt_q != 12'hFFF) begin
                px_cnt_d = px_cnt_q + 12'd1;
            end
        end else if (w_line_end) begin
            px_cnt_d = 12'd0;
        end
    end

    always_comb begin
        state_d    = state_q;
        line_cnt_d = line_cnt_q;
        fill_rem_d = fill_rem_q;
        pxf_cnt_d  = pxf_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        data_d     = 24'd0;
        dvo_d      = 1'b0;
        eof_d      = 1'b0;
        ovr_d      = 1'b0;
        sticky_d   = sticky_q;
        busy_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (w_vs_rise) begin
                    state_d    = ST_PASS;
                    line_cnt_d = 12'd0;
                end
            end

            ST_PASS: begin
                dvo_d  = dataValid_i && (line_cnt_q < V_DISP) && w_px_ok;
                data_d = dvo_d ? data_i : 24'd0;
                if (w_vs_rise) begin
                    if (w_eff == V_DISP) begin
                        eof_d      = 1'b1;
                        line_cnt_d = 12'd0;
                    end else begin
                        line_cnt_d = w_eff;
                        fill_rem_d = V_DISP - w_eff;
                        pxf_cnt_d  = 12'd0;
                        state_d    = ST_FILL_LINE;
                    end
                end else if (w_line_end && (line_cnt_q < V_DISP)) begin
                    line_cnt_d = line_cnt_q + 12'd1;
                end
            end

            ST_FILL_LINE: begin
                dvo_d  = 1'b1;
                data_d = C_FILL;
                if (pxf_cnt_q == H_DISP - 12'd1) begin
                    line_cnt_d = line_cnt_q + 12'd1;
                    fill_rem_d = fill_rem_q - 12'd1;
                    gap_cnt_d  = 12'd0;
                    state_d    = ST_FILL_GAP;
                end else begin
                    pxf_cnt_d = pxf_cnt_q + 12'd1;
                end
            end

            ST_FILL_GAP: begin
                if (gap_cnt_q == H_GAP - 12'd1) begin
                    if (fill_rem_q != 12'd0) begin
                        pxf_cnt_d = 12'd0;
                        state_d   = ST_FILL_LINE;
                    end else begin
                        eof_d      = 1'b1;
                        line_cnt_d = 12'd0;
                        state_d    = ST_PASS;
                    end
                end else begin
                    gap_cnt_d = gap_cnt_q + 12'd1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Input activity during a fill wins over any fill progress this cycle;
        // the colliding pixel opens the next frame at line 0.
        if (w_abort) begin
            state_d    = ST_PASS;
            line_cnt_d = 12'd0;
            eof_d      = 1'b1;
            ovr_d      = 1'b1;
            sticky_d   = 1'b1;
            dvo_d      = dataValid_i && w_px_ok;
            data_d     = dvo_d ? data_i : 24'd0;
        end

        busy_d = (state_d == ST_FILL_LINE) || (state_d == ST_FILL_GAP);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            vs_q       <= 1'b0;
            dv_q       <= 1'b0;
            px_cnt_q   <= 12'd0;
            line_cnt_q <= 12'd0;
            fill_rem_q <= 12'd0;
            pxf_cnt_q  <= 12'd0;
            gap_cnt_q  <= 12'd0;
            data_q     <= 24'd0;
            dvo_q      <= 1'b0;
            eof_q      <= 1'b0;
            ovr_q      <= 1'b0;
            sticky_q   <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            vs_q       <= vsync_i;
            dv_q       <= dataValid_i;
            px_cnt_q   <= px_cnt_d;
            line_cnt_q <= line_cnt_d;
            fill_rem_q <= fill_rem_d;
            pxf_cnt_q  <= pxf_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            data_q     <= data_d;
            dvo_q      <= dvo_d;
            eof_q      <= eof_d;
            ovr_q      <= ovr_d;
            sticky_q   <= sticky_d;
            busy_q     <= busy_d;
        end
    end

    assign data_o       = data_q;
    assign dataValid_o  = dvo_q;
    assign eof_o        = eof_q;
    assign overrun_o    = ovr_q;
    assign ovr_sticky_o = sticky_q;
    assign busy_o       = busy_q;
    assign line_cnt_o   = line_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_frame_fill_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_frame_fill_ctrl
//  Purpose  : Directed vector bench for frame_fill_ctrl (H_DISP=8, V_DISP=4,
//             H_GAP=2); FRAME_FILL_DEBUG_COLOR_EN selects the expected fill.
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_frame_fill_ctrl;

    localparam logic [11:0] H_DISP = 12'd8;
    localparam logic [11:0] V_DISP = 12'd4;
    localparam logic [11:0] H_GAP  = 12'd2;
`ifdef FRAME_FILL_DEBUG_COLOR_EN
    localparam int FILL = 32'h00FF00FF;
`else
    localparam int FILL = 32'h00000000;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        vsync_i = 1'b0;
    logic        dataValid_i = 1'b0;
    logic [23:0] data_i = 24'd0;
    logic [23:0] data_o;
    logic        dataValid_o, eof_o, overrun_o, ovr_sticky_o, busy_o;
    logic [11:0] line_cnt_o;

    frame_fill_ctrl #(.H_DISP(H_DISP), .V_DISP(V_DISP), .H_GAP(H_GAP)) dut (
        .clk(clk), .rst_n(rst_n), .vsync_i(vsync_i), .data_i(data_i),
        .dataValid_i(dataValid_i), .data_o(data_o), .dataValid_o(dataValid_o),
        .eof_o(eof_o), .overrun_o(overrun_o), .ovr_sticky_o(ovr_sticky_o),
        .busy_o(busy_o), .line_cnt_o(line_cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          scen;
        logic        vs;
        logic        dv;
        logic [23:0] d;
        logic [40:0] exp;   // {dv, data, eof, ovr, sticky, busy, line_cnt}
    } vec_t;

    vec_t tbl[$];
    int   cur_scen = 0;
    int   n_checks = 0;
    int   n_pass   = 0;

    function automatic logic [40:0] pack(int dv, int d, int eof, int ovr, int stk, int busy, int lc);
        return {dv[0], d[23:0], eof[0], ovr[0], stk[0], busy[0], lc[11:0]};
    endfunction

    function automatic logic [40:0] snap();
        return {dataValid_o, data_o, eof_o, overrun_o, ovr_sticky_o, busy_o, line_cnt_o};
    endfunction

    task automatic add(input int vs, input int dv, input int d, input logic [40:0] exp);
        vec_t v;
        v.scen = cur_scen;
        v.vs   = vs[0];
        v.dv   = dv[0];
        v.d    = d[23:0];
        v.exp  = exp;
        tbl.push_back(v);
    endtask

    task automatic add_idle(input int stk, input int lc);
        add(0, 0, 0, pack(0, 0, 0, 0, stk, 0, lc));
    endtask

    // Input line of npx pixels followed by one idle cycle; lc is the count
    // seen while the line is in flight, lc_after once it has ended.
    task automatic add_line(input int base, input int npx, input int lc, input int lc_after,
                            input int stk, input int emit);
        for (int p = 0; p < npx; p++) begin
            if (emit != 0 && p < 8)
                add(0, 1, base + p, pack(1, base + p, 0, 0, stk, 0, lc));
            else
                add(0, 1, base + p, pack(0, 0, 0, 0, stk, 0, lc));
        end
        add_idle(stk, lc_after);
    endtask

    // nl fill lines of 8 cycles with 2-cycle gaps, closing with eof.
    task automatic add_fill(input int nl, input int lc0, input int stk);
        for (int i = 0; i < nl; i++) begin
            for (int k = 1; k <= 8; k++)
                add(0, 0, 0, pack(1, FILL, 0, 0, stk, 1, (k == 8) ? lc0 + i + 1 : lc0 + i));
            add(0, 0, 0, pack(0, 0, 0, 0, stk, 1, lc0 + i + 1));
            if (i == nl - 1)
                add(0, 0, 0, pack(0, 0, 1, 0, stk, 0, 0));
            else
                add(0, 0, 0, pack(0, 0, 0, 0, stk, 1, lc0 + i + 1));
        end
    endtask

    task automatic chk(input string nm, input logic [40:0] got, input logic [40:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got dv=%0b d=%h eof=%0b ovr=%0b stk=%0b busy=%0b lc=%0d, expected dv=%0b d=%h eof=%0b ovr=%0b stk=%0b busy=%0b lc=%0d",
                     nm, got[40], got[39:16], got[15], got[14], got[13], got[12], got[11:0],
                     exp[40], exp[39:16], exp[15], exp[14], exp[13], exp[12], exp[11:0]);
        end
    endtask

    initial begin
        // 1: pre-vsync input after reset release is dropped
        cur_scen = 1;
        for (int i = 0; i < 4; i++) add(0, 1, 32'h00ABCD00 + i, pack(0, 0, 0, 0, 0, 0, 0));
        add_idle(0, 0);
        add(1, 0, 0, pack(0, 0, 0, 0, 0, 0, 0));
        add_idle(0, 0);

        // 2: full frame passes through bit-exact
        cur_scen = 2;
        for (int l = 0; l < 4; l++) add_line(l * 16, 8, l, l + 1, 0, 1);
        add(1, 0, 0, pack(0, 0, 1, 0, 0, 0, 0));
        add_idle(0, 0);

        // 3: short frame gets two fill lines
        cur_scen = 3;
        for (int l = 0; l < 2; l++) add_line(32'h00A00000 + l * 16, 8, l, l + 1, 0, 1);
        add(1, 0, 0, pack(0, 0, 0, 0, 0, 1, 2));
        add_fill(2, 2, 0);
        add_idle(0, 0);

        // 4: long and wide frame is cropped to 4x8
        cur_scen = 4;
        for (int l = 0; l < 6; l++)
            add_line(32'h00B00000 + l * 16, 10, (l < 4) ? l : 4, (l < 3) ? l + 1 : 4, 0, (l < 4) ? 1 : 0);
        add(1, 0, 0, pack(0, 0, 1, 0, 0, 0, 0));
        add_idle(0, 0);

        // 5: input pixel on the 3rd fill cycle aborts and is forwarded
        cur_scen = 5;
        add_line(32'h00C00000, 8, 0, 1, 0, 1);
        add(1, 0, 0, pack(0, 0, 0, 0, 0, 1, 1));
        add(0, 0, 0, pack(1, FILL, 0, 0, 0, 1, 1));
        add(0, 0, 0, pack(1, FILL, 0, 0, 0, 1, 1));
        add(0, 1, 32'h00123456, pack(1, 32'h00123456, 1, 1, 1, 0, 0));
        add_idle(1, 1);
        add_idle(1, 1);

        // 6: vsync during a fill gap aborts and closes an empty frame
        cur_scen = 6;
        add(1, 0, 0, pack(0, 0, 0, 0, 1, 1, 1));
        for (int k = 1; k <= 8; k++) add(0, 0, 0, pack(1, FILL, 0, 0, 1, 1, (k == 8) ? 2 : 1));
        add(1, 0, 0, pack(0, 0, 1, 1, 1, 0, 0));
        add_idle(1, 0);

        // 7: line end coincident with vsync counts once (3 lines -> 1 fill)
        cur_scen = 7;
        add_line(32'h00D00000, 8, 0, 1, 1, 1);
        add_line(32'h00D00010, 8, 1, 2, 1, 1);
        for (int p = 0; p < 8; p++) add(0, 1, 32'h00D00020 + p, pack(1, 32'h00D00020 + p, 0, 0, 1, 0, 2));
        add(1, 0, 0, pack(0, 0, 0, 0, 1, 1, 3));
        add_fill(1, 3, 1);
        add_idle(1, 0);

        // Reset held with active input: outputs stay cleared
        rst_n       = 1'b0;
        dataValid_i = 1'b1;
        data_i      = 24'h111111;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("reset_hold", snap(), pack(0, 0, 0, 0, 0, 0, 0));
        end
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            vsync_i     = tbl[i].vs;
            dataValid_i = tbl[i].dv;
            data_i      = tbl[i].d;
            @(negedge clk);
            chk($sformatf("vec%0d_scen%0d", i, tbl[i].scen), snap(), tbl[i].exp);
        end

        // Asynchronous reset in the middle of a fill line
        for (int p = 0; p < 8; p++) begin
            dataValid_i = 1'b1; data_i = 24'(p); vsync_i = 1'b0;
            @(negedge clk);
        end
        dataValid_i = 1'b0; data_i = 24'd0;
        @(negedge clk);
        vsync_i = 1'b1;
        @(negedge clk);
        vsync_i = 1'b0;
        repeat (3) @(negedge clk);
        chk("fill_before_reset", snap(), pack(1, FILL, 0, 0, 1, 1, 1));
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_mid_fill", snap(), pack(0, 0, 0, 0, 0, 0, 0));
        dataValid_i = 1'b1; data_i = 24'h777777;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("no_fill_resume", snap(), pack(0, 0, 0, 0, 0, 0, 0));
        end
        dataValid_i = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
